// File: rtl/tree_route_decoder.sv
// tree_route_decoder: single-flit routing stage for the tree NoC. Each flit is reported on sel, then forwarded on out0 or out1.
// Optional feature macro ROUTE_DEC_STATS_EN adds 16-bit per-port forward counters cnt0/cnt1.
module tree_route_decoder #(
  parameter int unsigned       DATA_W    = 9,
  parameter int unsigned       ADDR_W    = 4,
  parameter int unsigned       ADDR_LSB  = 5,
  parameter int unsigned       LEVEL     = 2,
  parameter logic [ADDR_W-1:0] NODE_ADDR = 4'b1000,
  parameter bit                LEAF      = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              sel_valid,
  input  logic              sel_ready,
  output logic              sel_data,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data
`ifdef ROUTE_DEC_STATS_EN
  ,
  output logic [15:0]       cnt0,
  output logic [15:0]       cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Leaf compare mask: LEVEL ones starting at the address-field MSB.
  localparam logic [ADDR_W-1:0] LEVEL_MASK = ~({ADDR_W{1'b1}} >> LEVEL);

  if (LEVEL >= ADDR_W) begin : g_bad_level
    $error("tree_route_decoder: LEVEL must be less than ADDR_W");
  end
  if (ADDR_LSB + ADDR_W > DATA_W) begin : g_bad_field
    $error("tree_route_decoder: address field exceeds DATA_W");
  end

  function automatic logic route_dir(input logic [DATA_W-1:0] flit);
    logic [ADDR_W-1:0] addr;
    addr = flit[ADDR_LSB +: ADDR_W];
    if (LEAF) begin
      route_dir = ((addr & LEVEL_MASK) == NODE_ADDR) ? 1'b0 : 1'b1;
    end else begin
      route_dir = addr[ADDR_W-1-LEVEL];
    end
  endfunction

  state_t              state_r;
  state_t              state_s;
  logic                dir_r;
  logic                sel_valid_r;
  logic                out0_valid_r;
  logic                out1_valid_r;
  logic [DATA_W-1:0]   out0_data_r;
  logic [DATA_W-1:0]   out1_data_r;
  logic                in_dir_s;
  logic                dir_ready_s;
  logic                capture_s;
  logic                out_fire_s;
  logic                ready_s;

  assign in_dir_s    = route_dir(in_data);
  assign dir_ready_s = dir_r ? out1_ready : out0_ready;

  // Next-state, capture and out-handshake decode.
  always_comb begin
    state_s    = state_r;
    capture_s  = 1'b0;
    out_fire_s = 1'b0;
    ready_s    = 1'b0;
    case (state_r)
      IDLE: begin
        ready_s = 1'b1;
        if (in_valid) begin
          capture_s = 1'b1;
          state_s   = SEL;
        end else begin
          state_s   = IDLE;
        end
      end
      SEL: begin
        if (sel_ready) begin
          state_s = OUT;
        end else begin
          state_s = SEL;
        end
      end
      OUT: begin
        ready_s = dir_ready_s;
        if (dir_ready_s) begin
          out_fire_s = 1'b1;
          if (in_valid) begin
            capture_s = 1'b1;
            state_s   = SEL;
          end else begin
            state_s   = IDLE;
          end
        end else begin
          state_s = OUT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Ready is combinational by design so a new flit can be taken on the out handshake.
  assign in_ready = ready_s & ~reset;

  // State, direction, registered valids and the per-port data holding registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      dir_r        <= 1'b0;
      sel_valid_r  <= 1'b0;
      out0_valid_r <= 1'b0;
      out1_valid_r <= 1'b0;
      out0_data_r  <= {DATA_W{1'b0}};
      out1_data_r  <= {DATA_W{1'b0}};
    end else begin
      state_r      <= state_s;
      sel_valid_r  <= (state_s == SEL);
      out0_valid_r <= (state_s == OUT) && (dir_r == 1'b0);
      out1_valid_r <= (state_s == OUT) && (dir_r == 1'b1);
      if (capture_s) begin
        dir_r <= in_dir_s;
        if (in_dir_s) begin
          out1_data_r <= in_data;
        end else begin
          out0_data_r <= in_data;
        end
      end
    end
  end

  assign sel_valid  = sel_valid_r;
  assign sel_data   = dir_r;
  assign out0_valid = out0_valid_r;
  assign out0_data  = out0_data_r;
  assign out1_valid = out1_valid_r;
  assign out1_data  = out1_data_r;

`ifdef ROUTE_DEC_STATS_EN
  logic [15:0] cnt0_r;
  logic [15:0] cnt1_r;

  // Per-port forward counters; they wrap naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_r <= 16'd0;
      cnt1_r <= 16'd0;
    end else if (out_fire_s) begin
      if (dir_r) begin
        cnt1_r <= cnt1_r + 16'd1;
      end else begin
        cnt0_r <= cnt0_r + 16'd1;
      end
    end
  end

  assign cnt0 = cnt0_r;
  assign cnt1 = cnt1_r;
`endif

endmodule
